// File: rtl/dm_copy_pkg.sv
// Shared types and constants for the data-memory copy engine.
package dm_copy_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One side's view of the data-memory port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              re;
        logic              we;
    } port_t;

    // Clear the byte-offset bits so every engine access is word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dm_copy_engine_if.sv
// Control, CPU-side and data-memory-side signals of the copy engine.
interface dm_copy_engine_if;
    import dm_copy_pkg::*;

    // Copy control
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;

    // CPU data-memory request
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_re;
    logic              cpu_we;

    // Data-memory port
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_re;
    logic              dm_we;
    logic [DATA_W-1:0] dm_rdata;
    logic              grant;

    // The engine owns the memory port, so it is the master side.
    modport master (
        input  start, src_addr, dst_addr, word_count,
        input  cpu_addr, cpu_wdata, cpu_re, cpu_we,
        input  dm_rdata,
        output busy, done,
        output dm_addr, dm_wdata, dm_re, dm_we, grant
    );

    // CPU datapath plus data memory, seen from the outside.
    modport slave (
        output start, src_addr, dst_addr, word_count,
        output cpu_addr, cpu_wdata, cpu_re, cpu_we,
        output dm_rdata,
        input  busy, done,
        input  dm_addr, dm_wdata, dm_re, dm_we, grant
    );

endinterface

// File: rtl/dm_port_mux.sv
// Selects which side drives the data-memory port; the CPU unless the engine holds grant.
module dm_port_mux
    import dm_copy_pkg::*;
(
    input  logic  grant,
    input  port_t cpu,
    input  port_t eng,
    output port_t dm
);

    // Pure selection: an idle CPU request passes through with re/we low.
    always_comb begin
        dm = cpu;
        if (grant) begin
            dm = eng;
        end
    end

endmodule

// File: rtl/dm_copy_engine.sv
// Word-copy engine that steals free data-memory cycles from the CPU.
module dm_copy_engine
    import dm_copy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    dm_copy_engine_if.master  bus
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] buffer;

    logic              cpu_access;
    logic              want;
    logic              grant;
    port_t             cpu_port;
    port_t             eng_port;
    port_t             dm_port;

    assign cpu_access = bus.cpu_re | bus.cpu_we;

    assign cpu_port = '{
        addr:  bus.cpu_addr,
        wdata: bus.cpu_wdata,
        re:    bus.cpu_re,
        we:    bus.cpu_we
    };

    // State register; reset aborts any copy in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state; a CPU access freezes READ/WRITE for that cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = (bus.word_count == CNT_W'(0)) ? DONE : READ;
                end
            end
            READ: begin
                if (!cpu_access) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (!cpu_access) begin
                    next_state = (cnt == CNT_W'(1)) ? DONE : READ;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Engine port request, grant and status, all decoded from state and CPU activity.
    always_comb begin
        eng_port.addr  = src;
        eng_port.wdata = buffer;
        eng_port.re    = 1'b0;
        eng_port.we    = 1'b0;
        want           = 1'b0;
        case (state)
            READ: begin
                want        = 1'b1;
                eng_port.re = 1'b1;
            end
            WRITE: begin
                want          = 1'b1;
                eng_port.addr = dst;
                eng_port.we   = 1'b1;
            end
            default: begin
                want = 1'b0;
            end
        endcase
        grant    = want & ~cpu_access;
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Copy parameters, counters and the word buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src    <= '0;
            dst    <= '0;
            cnt    <= '0;
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src <= word_align(bus.src_addr);
                        dst <= word_align(bus.dst_addr);
                        cnt <= bus.word_count;
                    end
                end
                READ: begin
                    if (grant) begin
                        buffer <= bus.dm_rdata;
                    end
                end
                WRITE: begin
                    if (grant) begin
                        src <= src + ADDR_W'(WORD_BYTES);
                        dst <= dst + ADDR_W'(WORD_BYTES);
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    dm_port_mux u_port_mux (
        .grant (grant),
        .cpu   (cpu_port),
        .eng   (eng_port),
        .dm    (dm_port)
    );

    assign bus.dm_addr  = dm_port.addr;
    assign bus.dm_wdata = dm_port.wdata;
    assign bus.dm_re    = dm_port.re;
    assign bus.dm_we    = dm_port.we;
    assign bus.grant    = grant;

endmodule

// File: tb/tb_dm_copy_engine.sv
// Scoreboard bench: stimulus queues expected reads, writes, loads and done cycles; a monitor checks them.
module tb_dm_copy_engine;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    dm_copy_engine_if bus ();

    dm_copy_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected-event queues filled by stimulus, drained by the monitor.
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    int          done_q[$];
    logic [31:0] ld_q[$];

    int applied     = 0;
    int miscompares = 0;
    int timeouts    = 0;
    bit end_check   = 1'b0;
    bit end_done    = 1'b0;

    logic [31:0] mon_e;
    wr_t         mon_w;
    int          mon_c;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 64-word data memory, combinational read, aliased on address bits [7:2].
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (bus.dm_we) mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
    end
    assign bus.dm_rdata = mem[bus.dm_addr[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        applied++;
        miscompares++;
        $display("FAIL %s: got event with value %h, expected none (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: compare every observable port event against the queues.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_busy",  32'(bus.busy),  32'd0);
            chk("reset_done",  32'(bus.done),  32'd0);
            chk("reset_grant", 32'(bus.grant), 32'd0);
            chk("reset_dm_we", 32'(bus.dm_we), 32'd0);
        end else begin
            if (bus.grant) begin
                chk("cpu_quiet_on_grant", 32'(bus.cpu_re | bus.cpu_we), 32'd0);
                if (bus.dm_re) begin
                    if (rd_q.size() == 0) unexpected("engine_read", bus.dm_addr);
                    else begin
                        mon_e = rd_q.pop_front();
                        chk("engine_read_addr", bus.dm_addr, mon_e);
                    end
                end
                if (bus.dm_we) begin
                    if (wr_q.size() == 0) unexpected("engine_write", bus.dm_addr);
                    else begin
                        mon_w = wr_q.pop_front();
                        chk("engine_write_addr", bus.dm_addr, mon_w.addr);
                        chk("engine_write_data", bus.dm_wdata, mon_w.data);
                    end
                end
            end else if (bus.cpu_re | bus.cpu_we | bus.dm_re | bus.dm_we) begin
                chk("cpu_pass_we",   32'(bus.dm_we), 32'(bus.cpu_we));
                chk("cpu_pass_re",   32'(bus.dm_re), 32'(bus.cpu_re));
                chk("cpu_pass_addr", bus.dm_addr,    bus.cpu_addr);
                if (bus.cpu_we) chk("cpu_pass_wdata", bus.dm_wdata, bus.cpu_wdata);
                if (bus.cpu_re) begin
                    if (ld_q.size() == 0) unexpected("cpu_load", bus.dm_rdata);
                    else begin
                        mon_e = ld_q.pop_front();
                        chk("cpu_load_data", bus.dm_rdata, mon_e);
                    end
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) unexpected("done_pulse", 32'(cyc));
                else begin
                    mon_c = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(mon_c));
                end
            end
        end
        if (end_check && !end_done) begin
            chk("left_reads",  32'(rd_q.size()),   32'd0);
            chk("left_writes", 32'(wr_q.size()),   32'd0);
            chk("left_dones",  32'(done_q.size()), 32'd0);
            chk("left_loads",  32'(ld_q.size()),   32'd0);
            end_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
        tick();
        bus.cpu_re = 1'b0; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic cpu_load(input logic [31:0] a, input logic [31:0] exp);
        tick();
        bus.cpu_re = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
        ld_q.push_back(exp);
    endtask

    task automatic cpu_idle();
        tick();
        bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
    endtask

    task automatic exp_rd(input logic [31:0] a);
        rd_q.push_back(a);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    // Pulse start for one cycle; done_lat counts cycles from the sampling edge (negative: no done expected).
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input int done_lat);
        tick();
        bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.word_count = n;
        if (done_lat >= 0) done_q.push_back(cyc + 1 + done_lat);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy) return;
            tick();
        end
        timeouts++;
        $display("FAIL wait_idle: busy still %0d after %0d cycles, expected 0", bus.busy, budget);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.word_count = '0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_re = 1'b0; bus.cpu_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Basic 4-word copy 0x0 -> 0x40, done 9 cycles after start
        cpu_store(32'h00, 32'h11111111);
        cpu_store(32'h04, 32'h22222222);
        cpu_store(32'h08, 32'h33333333);
        cpu_store(32'h0C, 32'h44444444);
        cpu_idle();
        for (int i = 0; i < 4; i++) begin
            exp_rd(32'(i * 4));
            exp_wr(32'h40 + 32'(i * 4), 32'h11111111 * 32'(i + 1));
        end
        do_start(32'h0, 32'h40, 16'd4, 8);
        wait_idle(40);
        cpu_load(32'h40, 32'h11111111);
        cpu_load(32'h44, 32'h22222222);
        cpu_load(32'h48, 32'h33333333);
        cpu_load(32'h4C, 32'h44444444);
        cpu_load(32'h00, 32'h11111111);
        cpu_load(32'h0C, 32'h44444444);
        cpu_idle();

        // Contention: CPU stores every other cycle, 7 contended cycles -> done at 8+7
        for (int i = 0; i < 4; i++) begin
            exp_rd(32'(i * 4));
            exp_wr(32'h60 + 32'(i * 4), 32'h11111111 * 32'(i + 1));
        end
        do_start(32'h0, 32'h60, 16'd4, 15);
        for (int i = 0; i < 15; i++) begin
            bus.cpu_we = (i % 2 == 1); bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'hAAAAAAAA;
            tick();
        end
        bus.cpu_we = 1'b0;
        wait_idle(40);
        cpu_load(32'h80, 32'hAAAAAAAA);
        cpu_load(32'h60, 32'h11111111);
        cpu_load(32'h6C, 32'h44444444);
        cpu_idle();

        // count=0: done on the next cycle, no memory access
        do_start(32'h0, 32'h40, 16'd0, 0);
        wait_idle(10);

        // Start while busy is ignored
        exp_rd(32'h00); exp_wr(32'hC0, 32'h11111111);
        exp_rd(32'h04); exp_wr(32'hC4, 32'h22222222);
        do_start(32'h0, 32'hC0, 16'd2, 4);
        tick();
        bus.start = 1'b1; bus.src_addr = 32'h100; bus.dst_addr = 32'h90; bus.word_count = 16'd5;
        tick();
        bus.start = 1'b0;
        wait_idle(40);
        cpu_load(32'hC0, 32'h11111111);
        cpu_load(32'hC4, 32'h22222222);
        cpu_idle();

        // Address wrap: third read comes from 0
        cpu_store(32'hFFFFFFF8, 32'h62626262);
        cpu_store(32'hFFFFFFFC, 32'h63636363);
        cpu_idle();
        exp_rd(32'hFFFFFFF8); exp_wr(32'h20, 32'h62626262);
        exp_rd(32'hFFFFFFFC); exp_wr(32'h24, 32'h63636363);
        exp_rd(32'h00000000); exp_wr(32'h28, 32'h11111111);
        do_start(32'hFFFFFFF8, 32'h20, 16'd3, 6);
        wait_idle(40);
        cpu_load(32'h28, 32'h11111111);
        cpu_idle();

        // Reset during the write of word 2 of 4
        cpu_store(32'hA0, 32'hDEADBEEF);
        cpu_store(32'hA4, 32'hDEADBEEF);
        cpu_store(32'hA8, 32'hDEADBEEF);
        cpu_store(32'hAC, 32'hDEADBEEF);
        cpu_idle();
        exp_rd(32'h00); exp_wr(32'hA0, 32'h11111111);
        exp_rd(32'h04);
        do_start(32'h0, 32'hA0, 16'd4, -1);
        tick(); tick(); tick();
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_load(32'hA0, 32'h11111111);
        cpu_load(32'hA4, 32'hDEADBEEF);
        cpu_load(32'hA8, 32'hDEADBEEF);
        cpu_load(32'hAC, 32'hDEADBEEF);
        cpu_idle();
        exp_rd(32'h08); exp_wr(32'hA4, 32'h33333333);
        do_start(32'h8, 32'hA4, 16'd1, 2);
        wait_idle(20);
        cpu_load(32'hA4, 32'h33333333);
        cpu_idle();

        // Overlap dst = src + 4 with unaligned inputs: value 5 propagates
        cpu_store(32'h00, 32'h00000005);
        cpu_store(32'h04, 32'h99999999);
        cpu_store(32'h08, 32'h99999999);
        cpu_store(32'h0C, 32'h99999999);
        cpu_idle();
        exp_rd(32'h00); exp_wr(32'h04, 32'h5);
        exp_rd(32'h04); exp_wr(32'h08, 32'h5);
        exp_rd(32'h08); exp_wr(32'h0C, 32'h5);
        do_start(32'h3, 32'h6, 16'd3, 6);
        wait_idle(40);
        cpu_load(32'h04, 32'h5);
        cpu_load(32'h08, 32'h5);
        cpu_load(32'h0C, 32'h5);
        cpu_load(32'h00, 32'h5);
        cpu_idle();

        end_check = 1'b1;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares + timeouts);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dm_copy_engine.md
# dm_copy_engine

Word-copy engine that shares the single-cycle MIPS data-memory port with the CPU. The CPU starts a copy of `word_count` 32-bit words from `src_addr` to `dst_addr`, and the engine steals memory cycles whenever the CPU is not using the port. The block sits between the CPU datapath and the data memory and owns the data-memory port mux. It is the hardware equivalent of the Array-copy program.

## Interface
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, word width; fixed at 4 bytes per word.
- `CNT_W`, 16, width of the word-count field.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle copy request.
- `src_addr` in ADDR_W: source byte address.
- `dst_addr` in ADDR_W: destination byte address.
- `word_count` in CNT_W: number of words to copy.
- `busy` out 1: engine is not idle.
- `done` out 1: one-cycle completion pulse.
- `cpu_addr` in ADDR_W: CPU data-memory address.
- `cpu_wdata` in DATA_W: CPU store data.
- `cpu_re` in 1: CPU load (MemRead).
- `cpu_we` in 1: CPU store (MemWrite).
- `dm_addr` out ADDR_W: address to data memory.
- `dm_wdata` out DATA_W: write data to data memory.
- `dm_re` out 1: data-memory read enable.
- `dm_we` out 1: data-memory write enable.
- `dm_rdata` in DATA_W: data-memory read data; combinational read, big-endian word of bytes [a..a+3].
- `grant` out 1: engine owns the port this cycle.

## Operation
- **States**
  - IDLE, READ, WRITE, DONE.
  - Reset forces IDLE and clears all registers.
  - Reset values: `busy`=0, `done`=0, `grant`=0, word buffer=0.
- **IDLE**
  - `start`=1 latches src, dst and count, with address bits [1:0] forced to 00.
  - count=0 goes to DONE; otherwise goes to READ.
- **CPU priority**
  - CPU access is `cpu_re | cpu_we`.
  - When it is 1, `grant`=0, `dm_*` = `cpu_*`, and the engine holds state.
  - The CPU is never stalled.
- **READ**
  - If the port is free: `grant`=1, `dm_addr`=src, `dm_re`=1, `dm_we`=0.
  - At the edge: buffer ← `dm_rdata`, then go to WRITE.
- **WRITE**
  - If the port is free: `grant`=1, `dm_addr`=dst, `dm_wdata`=buffer, `dm_we`=1.
  - At the edge: src+=4, dst+=4, count−=1.
  - Go to DONE if the pre-decrement count was 1, else READ.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- **Control rules**
  - `busy` = (state ≠ IDLE).
  - `start` while busy is ignored; the latched parameters stay unchanged.
- **Address arithmetic**
  - Modulo 2^ADDR_W; wrap-around past 0xFFFFFFFC continues at 0.
- **Overlap**
  - Copy is strictly ascending, one word at a time.
  - With dst > src and overlapping regions, the propagated values are the defined result.
- **Idle port**
  - When neither side uses the port, `dm_re`=`dm_we`=0 and `dm_addr`=`cpu_addr`.
- **Reset mid-copy**
  - Aborts immediately; `dm_we` drops asynchronously.
  - Words already written stay written; no further writes occur.

## Timing
- `start` is sampled at edge E0; READ is active in cycle E0→E1.
- Uncontended copy of N≥1 words:
  - Final write commits at edge E2N.
  - `done` is high in cycle E2N→E2N+1.
  - `busy` is low after E2N+1.
- Each cycle with a CPU access during READ/WRITE adds exactly one cycle of latency.
- N=0: `done` in cycle E0→E1 with no memory access.
- `grant`, `dm_*` and the outputs are combinational from state and the `cpu_*` inputs.
- The buffer and counters are registered.
- No combinational path from `dm_rdata` to any output.

## Structure
- Package `dm_copy_pkg`: state enum (IDLE/READ/WRITE/DONE) and `WORD_BYTES`=4.
- One sub-module, `dm_port_mux`: combinational selection between CPU and engine port signals, driven by `grant`.
- The FSM, counters and buffer live in the top module.

## Test plan
- **Basic copy:** Data memory words 0..3 = 11111111, 22222222, 33333333, 44444444; start src=0, dst=0x40, count=4, CPU idle → words 16..19 equal the sources; `done` pulses at cycle 9 after `start`; the source words are unchanged.
- **Contention:** same copy with `cpu_we`=1 every other cycle (CPU writes AAAAAAAA to addr 0x80) → CPU writes never delayed; mem[0x80]=AAAAAAAA; copy correct; latency = 8 + number of contended READ/WRITE cycles.
- **count=0 and ignored start:** start with count=0 → `done` the next cycle, `dm_we` never asserted; a second `start` (src=0x100) asserted while busy → ignored, original copy completes.
- **Overlap and wrap:** mem[0]=5, src=0, dst=4, count=3 → words 1..3 all = 5. Separately src=0xFFFFFFF8, count=3 → third read is from address 0.
- **Reset mid-copy:** assert `reset` during the WRITE of word 2 of 4 → `dm_we` is 0 within the same cycle; `busy`=`done`=`grant`=0; only word 1 is copied; a subsequent start behaves normally.
